prog_clk_divider: RTL and testbench
===================================

Name: prog_clk_divider

Overview:
Programmable clock-enable divider, the parametrised successor to the fixed 50 MHz -> 1 MHz divider in the timer subsystem. It generates a 50% duty divided clock with a runtime-programmable half-period, in periodic or one-shot mode. It provides a per-period tick pulse, a sticky interrupt with overrun detection, and a status output for the bus-facing register wrapper.

Parameters:
CNT_W, 16, width of the half-period counter and reload register
RESET_HALF, 24, reset value of the reload shadow register (50 MHz -> 1 MHz when unprogrammed)

Ports:
Clk  in  1  system clock
ResetN  in  1  asynchronous active-low reset
run  in  1  level; 1 = divider active, 0 = stop and clear output
oneshot  in  1  mode, sampled at start: 0 = periodic, 1 = stop after one full period
half_period  in  CNT_W  reload value; output half-period = half_period+1 Clk cycles
load  in  1  single-cycle strobe; writes half_period into the shadow register
enable_irq  in  1  interrupt mask
clear_irq  in  1  single-cycle strobe; clears irq_pending and overrun
clk_div  out  1  divided clock, registered
tick  out  1  one-Clk pulse on each clk_div falling toggle (end of full period)
irq  out  1  irq_pending AND enable_irq
overrun  out  1  sticky; a period ended while irq_pending was already set
busy  out  1  1 while in state RUN

Behaviour:
- Reset: clk_div=0, tick=0, irq_pending=0, overrun=0, busy=0, counter=RESET_HALF, shadow=RESET_HALF, state=IDLE.
- Shadow register: load=1 writes half_period into shadow on the next edge, in any state. The counter reloads from shadow only at a toggle or at start, so a new value takes effect on the next half-period boundary. The current half-period is never truncated.
- FSM states: IDLE, RUN, DONE.
  - IDLE: counter=shadow, clk_div=0. When run=1, go to RUN, latch oneshot into mode_q, and load counter=shadow. If load occurs in the same cycle as the start, the counter uses the new half_period.
  - RUN: counter decrements each cycle. At counter==0: toggle clk_div and reload counter=shadow.
    - On a 1->0 toggle: tick=1 for that cycle and set the period event.
    - If mode_q=1 and the toggle is 1->0, go to DONE.
  - DONE: clk_div=0, counter holds. When run=0, go to IDLE. Restarting a one-shot requires run to drop and rise again.
  - Any state: run=0 goes to IDLE next cycle with clk_div=0, counter=shadow. No tick or event is generated by a stop.
- Timing:
  - First rising toggle of clk_div occurs shadow+1 cycles after the cycle in which the RUN state is entered.
  - Full period is 2*(shadow+1) cycles.
  - half_period=0 gives clk_div toggling every cycle (period 2) and tick every 2 cycles.
  - half_period = 2^CNT_W - 1 gives the maximum period with no wrap error. The counter never decrements below 0.
- Interrupt:
  - A period event sets irq_pending.
  - If irq_pending is already 1 when an event occurs and clear_irq is 0, overrun is set.
  - clear_irq clears both flags. If clear_irq and an event occur in the same cycle, the event wins: irq_pending=1 and overrun=0, so no event is lost.
  - Events are recorded regardless of enable_irq; only irq is masked.
- All outputs are registered except irq (one AND gate).
- Reset asserted mid-period returns all state to reset values immediately (asynchronously), including shadow=RESET_HALF.

Test Plan:
- Default shadow, run=1 periodic: clk_div rises 25 cycles after RUN entry, period 50 cycles, tick every 50 cycles aligned with the falling toggle.
- load half_period=3 mid-run while shadow=24: the current half-period completes at 25 cycles, then clk_div has a period of 8 and tick every 8 cycles.
- oneshot=1, half_period=4 loaded together with the run rise: exactly one high phase of 5 cycles, one low phase of 5 cycles, one tick, then busy=0 and clk_div=0 while run remains 1. Dropping and raising run restarts the one-shot.
- enable_irq=1, periodic half_period=1, no clear: irq after the first tick; second tick sets overrun=1. clear_irq issued in a tick cycle leaves irq=1, overrun=0.
- enable_irq=0: irq stays 0 while irq_pending sets. Raising enable_irq afterwards asserts irq on the same cycle.
- half_period=0: clk_div toggles every cycle. Deassert run mid-period: no tick, clk_div=0 next cycle. Assert ResetN=0 mid-run: all outputs 0 immediately, shadow returns to 24.

Source files
------------

// File: rtl/prog_clk_divider_if.sv
// Control/status bundle between the timer register wrapper and prog_clk_divider.
// master = register wrapper side, slave = divider side.
interface prog_clk_divider_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic             oneshot;
    logic [CNT_W-1:0] half_period;
    logic             load;
    logic             enable_irq;
    logic             clear_irq;
    logic             clk_div;
    logic             tick;
    logic             irq;
    logic             overrun;
    logic             busy;

    modport master (
        output run, oneshot, half_period, load, enable_irq, clear_irq,
        input  clk_div, tick, irq, overrun, busy
    );

    modport slave (
        input  run, oneshot, half_period, load, enable_irq, clear_irq,
        output clk_div, tick, irq, overrun, busy
    );
endinterface

// File: rtl/prog_clk_divider.sv
// Programmable 50% duty clock-enable divider with periodic/one-shot modes,
// per-period tick and a sticky interrupt with overrun detection.
module prog_clk_divider #(
    parameter int CNT_W      = 16,
    parameter int RESET_HALF = 24
) (
    input  logic                Clk,
    input  logic                ResetN,
    prog_clk_divider_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             mode_q, mode_d;
    logic             clk_div_q, clk_div_d;
    logic             tick_q, tick_d;
    logic             irq_pending_q, irq_pending_d;
    logic             overrun_q, overrun_d;
    logic             busy_q, busy_d;
    logic             period_event;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q       <= IDLE;
            cnt_q         <= CNT_W'(RESET_HALF);
            shadow_q      <= CNT_W'(RESET_HALF);
            mode_q        <= 1'b0;
            clk_div_q     <= 1'b0;
            tick_q        <= 1'b0;
            irq_pending_q <= 1'b0;
            overrun_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            mode_q        <= mode_d;
            clk_div_q     <= clk_div_d;
            tick_q        <= tick_d;
            irq_pending_q <= irq_pending_d;
            overrun_q     <= overrun_d;
            busy_q        <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        // shadow_d forwards a same-cycle load so a start picks up the new value
        shadow_d     = bus.load ? bus.half_period : shadow_q;
        mode_d       = mode_q;
        clk_div_d    = clk_div_q;
        tick_d       = 1'b0;
        period_event = 1'b0;

        case (state_q)
            IDLE: begin
                clk_div_d = 1'b0;
                cnt_d     = shadow_d;
                if (bus.run) begin
                    state_d = RUN;
                    mode_d  = bus.oneshot;
                end
            end
            RUN: begin
                if (!bus.run) begin
                    state_d   = IDLE;
                    clk_div_d = 1'b0;
                    cnt_d     = shadow_d;
                end else if (cnt_q == '0) begin
                    clk_div_d = ~clk_div_q;
                    cnt_d     = shadow_q;
                    if (clk_div_q) begin
                        tick_d       = 1'b1;
                        period_event = 1'b1;
                        if (mode_q) begin
                            state_d = DONE;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                clk_div_d = 1'b0;
                if (!bus.run) begin
                    state_d = IDLE;
                    cnt_d   = shadow_d;
                end
            end
            default: begin
                state_d   = IDLE;
                clk_div_d = 1'b0;
                cnt_d     = shadow_d;
            end
        endcase

        busy_d = (state_d == RUN);
    end

    always_comb begin
        irq_pending_d = irq_pending_q;
        overrun_d     = overrun_q;
        // A period event coinciding with clear_irq wins so the event is not lost
        if (period_event) begin
            irq_pending_d = 1'b1;
            if (bus.clear_irq) begin
                overrun_d = 1'b0;
            end else if (irq_pending_q) begin
                overrun_d = 1'b1;
            end
        end else if (bus.clear_irq) begin
            irq_pending_d = 1'b0;
            overrun_d     = 1'b0;
        end
    end

    assign bus.clk_div = clk_div_q;
    assign bus.tick    = tick_q;
    assign bus.irq     = irq_pending_q & bus.enable_irq;
    assign bus.overrun = overrun_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_prog_clk_divider.sv
// Scoreboard bench for prog_clk_divider: stimulus queues expected output
// snapshots and tick cycles; a negedge monitor pops and compares them.
module tb_prog_clk_divider;
    localparam int CNT_W = 16;

    localparam logic [4:0] M_CLK  = 5'b10000;
    localparam logic [4:0] M_TICK = 5'b01000;
    localparam logic [4:0] M_IRQ  = 5'b00100;
    localparam logic [4:0] M_OV   = 5'b00010;
    localparam logic [4:0] M_BUSY = 5'b00001;
    localparam logic [4:0] M_ALL  = 5'b11111;

    typedef struct {
        int unsigned cyc;
        logic [4:0]  mask;
        logic [4:0]  val;
        string       name;
    } snap_t;

    logic        Clk;
    logic        ResetN;
    int unsigned cyc;
    int unsigned n_checks;
    int unsigned n_pass;
    snap_t       sq[$];
    int unsigned tq[$];

    prog_clk_divider_if #(.CNT_W(CNT_W)) bus ();

    prog_clk_divider #(
        .CNT_W      (CNT_W),
        .RESET_HALF (24)
    ) dut (
        .Clk    (Clk),
        .ResetN (ResetN),
        .bus    (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic expect_snap(input int unsigned c, input logic [4:0] m,
                               input logic [4:0] v, input string n);
        snap_t s;
        s.cyc  = c;
        s.mask = m;
        s.val  = v;
        s.name = n;
        sq.push_back(s);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) step();
    endtask

    // Observed vector order: {clk_div, tick, irq, overrun, busy}
    always @(negedge Clk) begin
        logic [4:0] obs;
        snap_t      s;
        obs = {bus.clk_div, bus.tick, bus.irq, bus.overrun, bus.busy};
        while (sq.size() > 0 && sq[0].cyc <= cyc) begin
            s = sq.pop_front();
            n_checks++;
            if (s.cyc != cyc) begin
                $display("FAIL %s: snapshot for cycle %0d missed (now %0d)", s.name, s.cyc, cyc);
            end else if ((obs & s.mask) !== (s.val & s.mask)) begin
                $display("FAIL %s @cyc %0d: got %b required %b (mask %b)",
                         s.name, cyc, obs & s.mask, s.val & s.mask, s.mask);
            end else begin
                n_pass++;
            end
        end
        if (tq.size() > 0 && tq[0] == cyc) begin
            void'(tq.pop_front());
            n_checks++;
            if (bus.tick === 1'b1) n_pass++;
            else $display("FAIL tick @cyc %0d: got %b required 1", cyc, bus.tick);
        end else if (bus.tick !== 1'b0) begin
            n_checks++;
            $display("FAIL stray_tick @cyc %0d: got %b required 0", cyc, bus.tick);
        end
    end

    initial begin
        int unsigned t0, t1, t2;
        n_checks = 0;
        n_pass   = 0;
        ResetN          = 1'b0;
        bus.run         = 1'b0;
        bus.oneshot     = 1'b0;
        bus.half_period = '0;
        bus.load        = 1'b0;
        bus.enable_irq  = 1'b0;
        bus.clear_irq   = 1'b0;

        expect_snap(2, M_ALL, 5'b00000, "reset_state");
        wait_until(3);
        ResetN = 1'b1;

        // Periodic with default shadow, then reload to 3 mid-run, irq/overrun/clear, stop
        wait_until(5);
        t0 = cyc;
        expect_snap(t0+1,   M_CLK|M_TICK|M_BUSY, M_BUSY, "a_run_entry");
        expect_snap(t0+25,  M_CLK, 5'b0, "a_before_rise");
        expect_snap(t0+26,  M_CLK, M_CLK, "a_first_rise");
        expect_snap(t0+51,  M_ALL, M_TICK|M_BUSY, "a_first_fall_masked_irq");
        expect_snap(t0+52,  M_IRQ|M_TICK, 5'b0, "a_irq_masked");
        expect_snap(t0+60,  M_IRQ|M_OV, M_IRQ, "a_enable_irq_same_cycle");
        expect_snap(t0+76,  M_CLK, M_CLK, "a_old_half_completes");
        expect_snap(t0+80,  M_ALL, M_TICK|M_IRQ|M_OV|M_BUSY, "a_overrun_set");
        expect_snap(t0+83,  M_CLK, 5'b0, "a_new_low_phase");
        expect_snap(t0+84,  M_CLK, M_CLK, "a_new_rise");
        expect_snap(t0+88,  M_ALL, M_TICK|M_IRQ|M_BUSY, "a_clear_vs_event");
        expect_snap(t0+96,  M_ALL, M_TICK|M_IRQ|M_OV|M_BUSY, "a_overrun_again");
        expect_snap(t0+98,  M_IRQ|M_OV, 5'b0, "a_clear_irq");
        expect_snap(t0+101, M_CLK|M_BUSY, M_CLK|M_BUSY, "a_high_before_stop");
        expect_snap(t0+102, M_ALL, 5'b0, "a_stop");
        expect_snap(t0+104, M_ALL, 5'b0, "a_no_tick_after_stop");
        tq.push_back(t0+51);
        tq.push_back(t0+80);
        tq.push_back(t0+88);
        tq.push_back(t0+96);
        bus.run = 1'b1;
        wait_until(t0+60);
        bus.load        = 1'b1;
        bus.half_period = 16'd3;
        bus.enable_irq  = 1'b1;
        wait_until(t0+61);
        bus.load = 1'b0;
        wait_until(t0+87);
        bus.clear_irq = 1'b1;
        wait_until(t0+88);
        bus.clear_irq = 1'b0;
        wait_until(t0+97);
        bus.clear_irq = 1'b1;
        wait_until(t0+98);
        bus.clear_irq = 1'b0;
        wait_until(t0+101);
        bus.run = 1'b0;

        // One-shot with half_period=4 loaded at start, then restart
        t1 = t0 + 110;
        wait_until(t1);
        expect_snap(t1+1,  M_CLK|M_TICK|M_BUSY, M_BUSY, "b_run_entry");
        expect_snap(t1+5,  M_CLK, 5'b0, "b_before_rise");
        expect_snap(t1+6,  M_CLK|M_BUSY, M_CLK|M_BUSY, "b_rise");
        expect_snap(t1+10, M_CLK|M_BUSY, M_CLK|M_BUSY, "b_high_end");
        expect_snap(t1+11, M_ALL, M_TICK|M_IRQ, "b_oneshot_done");
        expect_snap(t1+12, M_ALL, M_IRQ, "b_done_hold");
        expect_snap(t1+20, M_ALL, M_IRQ, "b_done_run_high");
        expect_snap(t1+26, M_ALL, 5'b0, "b_idle_cleared");
        expect_snap(t1+28, M_CLK|M_BUSY, M_BUSY, "b_restart_entry");
        expect_snap(t1+32, M_CLK, 5'b0, "b_restart_before_rise");
        expect_snap(t1+33, M_CLK, M_CLK, "b_restart_rise");
        expect_snap(t1+38, M_ALL, M_TICK|M_IRQ, "b_restart_done");
        tq.push_back(t1+11);
        tq.push_back(t1+38);
        bus.run         = 1'b1;
        bus.oneshot     = 1'b1;
        bus.load        = 1'b1;
        bus.half_period = 16'd4;
        wait_until(t1+1);
        bus.load    = 1'b0;
        bus.oneshot = 1'b0;
        wait_until(t1+25);
        bus.run       = 1'b0;
        bus.clear_irq = 1'b1;
        wait_until(t1+26);
        bus.clear_irq = 1'b0;
        wait_until(t1+27);
        bus.run     = 1'b1;
        bus.oneshot = 1'b1;
        wait_until(t1+28);
        bus.oneshot = 1'b0;
        wait_until(t1+40);
        bus.run = 1'b0;

        // half_period=0, async reset mid-run, shadow back to default
        t2 = t1 + 45;
        wait_until(t2);
        expect_snap(t2+1,  M_CLK|M_BUSY, M_BUSY, "c_run_entry");
        expect_snap(t2+2,  M_CLK|M_TICK, M_CLK, "c_toggle_hi");
        expect_snap(t2+3,  M_CLK|M_TICK|M_BUSY, M_TICK|M_BUSY, "c_toggle_lo");
        expect_snap(t2+4,  M_CLK|M_TICK, M_CLK, "c_toggle_hi2");
        expect_snap(t2+9,  M_CLK|M_TICK, M_TICK, "c_toggle_lo4");
        expect_snap(t2+10, M_ALL, 5'b0, "c_async_reset");
        expect_snap(t2+11, M_ALL, 5'b0, "c_reset_held");
        expect_snap(t2+13, M_ALL, M_BUSY, "c_run_after_reset");
        expect_snap(t2+37, M_CLK, 5'b0, "c_default_before_rise");
        expect_snap(t2+38, M_CLK|M_BUSY, M_CLK|M_BUSY, "c_default_rise");
        expect_snap(t2+63, M_ALL, M_TICK|M_IRQ|M_BUSY, "c_default_fall");
        tq.push_back(t2+3);
        tq.push_back(t2+5);
        tq.push_back(t2+7);
        tq.push_back(t2+9);
        tq.push_back(t2+63);
        bus.run         = 1'b1;
        bus.load        = 1'b1;
        bus.half_period = 16'd0;
        wait_until(t2+1);
        bus.load = 1'b0;
        wait_until(t2+10);
        ResetN = 1'b0;
        wait_until(t2+12);
        ResetN = 1'b1;
        wait_until(t2+70);
        bus.run = 1'b0;
        wait_until(t2+75);

        while (sq.size() > 0) begin
            snap_t s;
            s = sq.pop_front();
            n_checks++;
            $display("FAIL %s: snapshot for cycle %0d never compared", s.name, s.cyc);
        end
        while (tq.size() > 0) begin
            int unsigned c;
            c = tq.pop_front();
            n_checks++;
            $display("FAIL tick: expected tick at cycle %0d never compared", c);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
